// File: rtl/tile_grid_renderer_pkg.sv
// Shared types and constant tables for the tile grid renderer:
// digit codes, FSM states, controller opcodes, font ROM and 2^e in BCD.
package tile_grid_pkg;

  // Digit code: 0-9 are decimal digits, plus blank and overflow glyphs.
  typedef logic [3:0] digit_t;
  localparam digit_t DIG_BLANK = 4'd10;
  localparam digit_t DIG_OVF   = 4'd11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR_CMD  = 3'd1,
    CLR_DATA = 3'd2,
    ROW_CMD  = 3'd3,
    ROW_DATA = 3'd4
  } state_t;

  // Controller opcodes: set page (OR in page number), column low/high nibble.
  localparam logic [7:0] CMD_PAGE   = 8'hB0;
  localparam logic [7:0] CMD_COL_LO = 8'h00;
  localparam logic [7:0] CMD_COL_HI = 8'h10;

  // The BCD table covers exponents up to 31, i.e. EXP_W up to 5.
  localparam int MAX_EXP_W  = 5;
  localparam int BCD_DIGITS = 10;

  // 2^e as packed BCD, least significant decimal digit in bits [3:0].
  localparam logic [39:0] POW2_BCD [32] = '{
    40'h0000000001, 40'h0000000002, 40'h0000000004, 40'h0000000008,
    40'h0000000016, 40'h0000000032, 40'h0000000064, 40'h0000000128,
    40'h0000000256, 40'h0000000512, 40'h0000001024, 40'h0000002048,
    40'h0000004096, 40'h0000008192, 40'h0000016384, 40'h0000032768,
    40'h0000065536, 40'h0000131072, 40'h0000262144, 40'h0000524288,
    40'h0001048576, 40'h0002097152, 40'h0004194304, 40'h0008388608,
    40'h0016777216, 40'h0033554432, 40'h0067108864, 40'h0134217728,
    40'h0268435456, 40'h0536870912, 40'h1073741824, 40'h2147483648
  };

  // Font ROM [code][column]; codes 12-15 never occur and render blank.
  localparam logic [7:0] FONT_ROM [16][3] = '{
    '{8'h7C, 8'h44, 8'h7C}, '{8'h00, 8'h00, 8'h7C},
    '{8'h74, 8'h54, 8'h5C}, '{8'h54, 8'h54, 8'h7C},
    '{8'h1C, 8'h10, 8'h7C}, '{8'h5C, 8'h54, 8'h74},
    '{8'h7C, 8'h54, 8'h74}, '{8'h04, 8'h04, 8'h7C},
    '{8'h7C, 8'h54, 8'h7C}, '{8'h5C, 8'h54, 8'h7C},
    '{8'h00, 8'h00, 8'h00}, '{8'h10, 8'h10, 8'h10},
    '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00}
  };

  // Font column lookup; column 3 is the inter-glyph spacer.
  function automatic logic [7:0] glyph_col(input digit_t code, input logic [1:0] col);
    logic [7:0] v;
    v = 8'h00;
    if (col != 2'd3) v = FONT_ROM[code][col];
    return v;
  endfunction

endpackage

// File: rtl/tile_grid_renderer_if.sv
// Byte stream from the renderer to the serial OLED controller.
// Valid/ready: a byte transfers on the CLK edge where CMD_VALID && CMD_READY;
// while CMD_VALID && !CMD_READY the master holds CMD_DATA/CMD_IS_DATA/CMD_LAST
// stable and never drops CMD_VALID (reset excepted).
interface tile_grid_renderer_if;
  logic [7:0] CMD_DATA;
  logic       CMD_IS_DATA;
  logic       CMD_LAST;
  logic       CMD_VALID;
  logic       CMD_READY;

  modport master (output CMD_DATA, output CMD_IS_DATA, output CMD_LAST,
                  output CMD_VALID, input CMD_READY);
  modport slave  (input CMD_DATA, input CMD_IS_DATA, input CMD_LAST,
                  input CMD_VALID, output CMD_READY);
endinterface

// File: rtl/tile_grid_renderer_digit_fmt.sv
// Registered exponent-to-digit-code formatter (one cycle latency).
// Output holds DIGITS codes, leftmost display position in the top nibble.
module tile_digit_fmt
  import tile_grid_pkg::*;
#(
  parameter int EXP_W  = 4,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [EXP_W-1:0]      i_exp,
  output logic [DIGITS*4-1:0]   o_digits
);

  logic [39:0]          w_bcd;
  logic [DIGITS*4-1:0]  w_digits;
  logic                 w_ovf;
  logic                 w_seen;
  logic [DIGITS*4-1:0]  r_digits;

  // Right-justify 2^e: blank leading zeros, whole field OVF if too wide.
  always_comb begin
    w_bcd    = POW2_BCD[5'(i_exp)];
    w_ovf    = 1'b0;
    w_seen   = 1'b0;
    w_digits = '0;
    for (int i = DIGITS; i < BCD_DIGITS; i++) begin
      if (w_bcd[i*4 +: 4] != 4'd0) w_ovf = 1'b1;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (w_bcd[i*4 +: 4] != 4'd0) w_seen = 1'b1;
      if (i_exp == '0)  w_digits[i*4 +: 4] = DIG_BLANK;
      else if (w_ovf)   w_digits[i*4 +: 4] = DIG_OVF;
      else if (w_seen)  w_digits[i*4 +: 4] = w_bcd[i*4 +: 4];
      else              w_digits[i*4 +: 4] = DIG_BLANK;
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_digits <= '0;
    else     r_digits <= w_digits;
  end

  assign o_digits = r_digits;

endmodule

// File: rtl/tile_grid_renderer.sv
// Tile grid renderer: turns a snapshot of tile exponents into page/column
// command bytes and glyph column bytes for an SSD13xx-style controller.
// Also performs full-panel clears and queues one refresh while busy.
module tile_grid_renderer
  import tile_grid_pkg::*;
#(
  parameter int GRID_N  = 4,
  parameter int EXP_W   = 4,
  parameter int DIGITS  = 4,
  parameter int GLYPH_W = 4,
  parameter int PAGES   = 8,
  parameter int COLS    = 128
) (
  input  logic                            CLK,
  input  logic                            ASYNC_RST,
  input  logic [GRID_N*GRID_N*EXP_W-1:0]  TILES,
  input  logic                            REFRESH,
  input  logic                            CLEAR,
  output logic                            BUSY,
  tile_grid_renderer_if.master            cmd
);

  localparam int PG_W      = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int RW_W      = (GRID_N > 1) ? $clog2(GRID_N) : 1;
  localparam int DG_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int GC_W      = $clog2(GLYPH_W);
  localparam int COL_W     = $clog2(COLS + 1);
  localparam int ROW_PITCH = PAGES / GRID_N;
  localparam int TW        = GRID_N * GRID_N * EXP_W;

  localparam logic [PG_W-1:0]  PG_LAST  = PG_W'(PAGES - 1);
  localparam logic [RW_W-1:0]  RW_LAST  = RW_W'(GRID_N - 1);
  localparam logic [DG_W-1:0]  DG_LAST  = DG_W'(DIGITS - 1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(GLYPH_W - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  if (GRID_N * DIGITS * GLYPH_W > COLS) begin : g_bad_cols
    $error("tile_grid_renderer: GRID_N*DIGITS*GLYPH_W exceeds COLS");
  end
  if (GRID_N > PAGES) begin : g_bad_pages
    $error("tile_grid_renderer: GRID_N exceeds PAGES");
  end
  if (GLYPH_W < 4 || EXP_W > MAX_EXP_W || DIGITS > BCD_DIGITS) begin : g_bad_glyph
    $error("tile_grid_renderer: GLYPH_W < 4, EXP_W > 5 or DIGITS > 10");
  end

  state_t              r_state, w_state_nxt;
  logic [PG_W-1:0]     r_page, w_page_nxt;
  logic [RW_W-1:0]     r_row, w_row_nxt;
  logic [COL_W-1:0]    r_idx, w_idx_nxt;
  logic [RW_W-1:0]     r_tile, w_tile_nxt;
  logic [DG_W-1:0]     r_digit, w_digit_nxt;
  logic [GC_W-1:0]     r_gcol, w_gcol_nxt;
  logic                r_pending, w_pending_nxt;
  logic [TW-1:0]       r_snap;
  logic                w_snap_load;

  logic                r_valid, r_is_data, r_last;
  logic [7:0]          r_data;
  logic                w_load, w_is_data, w_last, w_emit, w_busy;
  logic [7:0]          w_byte, w_page_cmd, w_glyph;
  digit_t              w_code;
  logic [EXP_W-1:0]    w_exp;
  logic [DIGITS*4-1:0] w_digits;

  // Output register may be (re)loaded when empty or being accepted this edge.
  assign w_emit = !r_valid || cmd.CMD_READY;
  assign w_busy = (r_state != IDLE) || r_valid;

  // Page command byte and glyph column for the current position.
  always_comb begin
    if (r_state == CLR_CMD) w_page_cmd = CMD_PAGE | 8'(r_page);
    else                    w_page_cmd = CMD_PAGE | 8'(int'(r_row) * ROW_PITCH);
    w_code  = w_digits[(DIGITS - 1 - int'(r_digit))*4 +: 4];
    w_glyph = (int'(r_gcol) < 3) ? glyph_col(w_code, r_gcol[1:0]) : 8'h00;
  end

  // Next-state, counter and byte-load logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_page_nxt    = r_page;
    w_row_nxt     = r_row;
    w_idx_nxt     = r_idx;
    w_tile_nxt    = r_tile;
    w_digit_nxt   = r_digit;
    w_gcol_nxt    = r_gcol;
    w_pending_nxt = r_pending;
    w_snap_load   = 1'b0;
    w_load        = 1'b0;
    w_byte        = 8'h00;
    w_is_data     = 1'b0;
    w_last        = 1'b0;
    if (REFRESH && w_busy) w_pending_nxt = 1'b1;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_pending_nxt = 1'b0;
          w_snap_load   = 1'b1;
          w_state_nxt   = ROW_CMD;
          w_row_nxt     = '0;
          w_idx_nxt     = '0;
        end else if (!r_valid) begin
          if (CLEAR) begin
            w_state_nxt   = CLR_CMD;
            w_page_nxt    = '0;
            w_idx_nxt     = '0;
            w_pending_nxt = REFRESH;
          end else if (REFRESH) begin
            w_snap_load = 1'b1;
            w_state_nxt = ROW_CMD;
            w_row_nxt   = '0;
            w_idx_nxt   = '0;
          end
        end
      end
      CLR_CMD, ROW_CMD: begin
        if (w_emit) begin
          w_load = 1'b1;
          if (r_idx == COL_W'(0))      w_byte = w_page_cmd;
          else if (r_idx == COL_W'(1)) w_byte = CMD_COL_LO;
          else                         w_byte = CMD_COL_HI;
          w_last = (r_idx == COL_W'(2));
          if (w_last) begin
            w_idx_nxt   = '0;
            w_tile_nxt  = '0;
            w_digit_nxt = '0;
            w_gcol_nxt  = '0;
            w_state_nxt = (r_state == CLR_CMD) ? CLR_DATA : ROW_DATA;
          end else begin
            w_idx_nxt = r_idx + COL_W'(1);
          end
        end
      end
      CLR_DATA: begin
        if (w_emit) begin
          w_load    = 1'b1;
          w_is_data = 1'b1;
          w_last    = (r_idx == COL_LAST);
          if (w_last) begin
            w_idx_nxt = '0;
            if (r_page == PG_LAST) begin
              w_state_nxt = IDLE;
            end else begin
              w_page_nxt  = r_page + PG_W'(1);
              w_state_nxt = CLR_CMD;
            end
          end else begin
            w_idx_nxt = r_idx + COL_W'(1);
          end
        end
      end
      ROW_DATA: begin
        if (w_emit) begin
          w_load    = 1'b1;
          w_is_data = 1'b1;
          w_byte    = w_glyph;
          w_last    = (r_tile == RW_LAST) && (r_digit == DG_LAST) && (r_gcol == GC_LAST);
          if (r_gcol == GC_LAST) begin
            w_gcol_nxt = '0;
            if (r_digit == DG_LAST) begin
              w_digit_nxt = '0;
              w_tile_nxt  = (r_tile == RW_LAST) ? '0 : r_tile + RW_W'(1);
            end else begin
              w_digit_nxt = r_digit + DG_W'(1);
            end
          end else begin
            w_gcol_nxt = r_gcol + GC_W'(1);
          end
          if (w_last) begin
            w_idx_nxt = '0;
            if (r_row == RW_LAST) begin
              w_state_nxt = IDLE;
            end else begin
              w_row_nxt   = r_row + RW_W'(1);
              w_state_nxt = ROW_CMD;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Prefetch: the formatter sees the tile the counters will point at next
  // cycle, so its registered digits line up with r_row/r_tile.
  always_comb begin
    w_exp = r_snap[(GRID_N*GRID_N - 1 - (int'(w_row_nxt)*GRID_N + int'(w_tile_nxt)))*EXP_W +: EXP_W];
  end

  tile_digit_fmt #(
    .EXP_W  (EXP_W),
    .DIGITS (DIGITS)
  ) u_fmt (
    .clk      (CLK),
    .rst      (ASYNC_RST),
    .i_exp    (w_exp),
    .o_digits (w_digits)
  );

  // FSM state, counters, pending flag and tile snapshot.
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      r_state   <= IDLE;
      r_page    <= '0;
      r_row     <= '0;
      r_idx     <= '0;
      r_tile    <= '0;
      r_digit   <= '0;
      r_gcol    <= '0;
      r_pending <= 1'b0;
      r_snap    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_page    <= w_page_nxt;
      r_row     <= w_row_nxt;
      r_idx     <= w_idx_nxt;
      r_tile    <= w_tile_nxt;
      r_digit   <= w_digit_nxt;
      r_gcol    <= w_gcol_nxt;
      r_pending <= w_pending_nxt;
      if (w_snap_load) r_snap <= TILES;
    end
  end

  // Output byte register: load a new byte or retire the accepted one.
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_is_data <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_data    <= w_byte;
      r_is_data <= w_is_data;
      r_last    <= w_last;
    end else if (r_valid && cmd.CMD_READY) begin
      r_valid   <= 1'b0;
    end
  end

  assign cmd.CMD_VALID   = r_valid;
  assign cmd.CMD_DATA    = r_data;
  assign cmd.CMD_IS_DATA = r_is_data;
  assign cmd.CMD_LAST    = r_last;
  assign BUSY            = w_busy;

endmodule

// File: tb/tb_tile_grid_renderer.sv
// Bench for tile_grid_renderer at default parameters: table-driven single
// tile frames, randomized frames under backpressure, clear, queued
// requests and asynchronous reset mid-frame.
module tb_tile_grid_renderer;

  localparam int TW      = 64;
  localparam int W       = 10;
  localparam int ROW_LEN = 3 + 64;
  localparam int LIMIT   = 30000;

  logic          clk;
  logic          rst;
  logic [TW-1:0] tiles;
  logic          refresh;
  logic          clear;
  logic          busy;

  tile_grid_renderer_if bus ();

  tile_grid_renderer dut (
    .CLK       (clk),
    .ASYNC_RST (rst),
    .TILES     (tiles),
    .REFRESH   (refresh),
    .CLEAR     (clear),
    .BUSY      (busy),
    .cmd       (bus.master)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int ready_pct = 100;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  logic       prev_stall = 1'b0;
  logic [9:0] prev_byte  = '0;

  logic [7:0] fc0 [10] = '{8'h7C,8'h00,8'h74,8'h54,8'h1C,8'h5C,8'h7C,8'h04,8'h7C,8'h5C};
  logic [7:0] fc1 [10] = '{8'h44,8'h00,8'h54,8'h54,8'h10,8'h54,8'h54,8'h04,8'h54,8'h54};
  logic [7:0] fc2 [10] = '{8'h7C,8'h7C,8'h5C,8'h7C,8'h7C,8'h74,8'h74,8'h7C,8'h7C,8'h7C};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // READY driver: re-randomised just after every rising edge.
  always @(posedge clk) begin
    #1 bus.CMD_READY = ($urandom_range(0, 99) < ready_pct);
  end

  // Monitor: collects accepted bytes and checks hold-while-stalled.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (!bus.CMD_VALID || {bus.CMD_IS_DATA, bus.CMD_LAST, bus.CMD_DATA} !== prev_byte) begin
          n_fail++;
          $display("FAIL stall_hold actual=v%0d/%0h required=v1/%0h", bus.CMD_VALID,
                   {bus.CMD_IS_DATA, bus.CMD_LAST, bus.CMD_DATA}, prev_byte);
        end
      end
      if (bus.CMD_VALID && bus.CMD_READY) begin
        got_q.push_back({bus.CMD_IS_DATA, bus.CMD_LAST, bus.CMD_DATA});
        last_acc = cyc;
      end
      prev_stall = bus.CMD_VALID && !bus.CMD_READY;
      prev_byte  = {bus.CMD_IS_DATA, bus.CMD_LAST, bus.CMD_DATA};
    end
  end

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int p = 0; p < 8; p++) begin
      exp_q.push_back({1'b0, 1'b0, 8'hB0 + 8'(p)});
      exp_q.push_back({1'b0, 1'b0, 8'h00});
      exp_q.push_back({1'b0, 1'b1, 8'h10});
      for (int c = 0; c < 128; c++) exp_q.push_back({1'b1, (c == 127), 8'h00});
    end
  endtask

  // Glyph column k of display code (0-9 digit, -1 blank, -2 overflow).
  function automatic logic [7:0] font(int code, int k);
    if (k == 3 || code == -1) return 8'h00;
    if (code == -2) return 8'h10;
    if (k == 0) return fc0[code];
    if (k == 1) return fc1[code];
    return fc2[code];
  endfunction

  task automatic model_refresh(input logic [TW-1:0] t);
    int        e, nd, code, cnt;
    longint    v, tmp, pw;
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back({1'b0, 1'b0, 8'hB0 + 8'(2*r)});
      exp_q.push_back({1'b0, 1'b0, 8'h00});
      exp_q.push_back({1'b0, 1'b1, 8'h10});
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
        e   = int'(t[(15 - (r*4 + c))*4 +: 4]);
        v   = longint'(1) << e;
        nd  = 0;
        tmp = v;
        while (tmp > 0) begin nd++; tmp = tmp / 10; end
        for (int p = 0; p < 4; p++) begin
          pw = 1;
          for (int q = 0; q < 3 - p; q++) pw = pw * 10;
          if (e == 0)            code = -1;
          else if (nd > 4)       code = -2;
          else if (3 - p >= nd)  code = -1;
          else                   code = int'((v / pw) % 10);
          for (int k = 0; k < 4; k++) begin
            cnt++;
            exp_q.push_back({1'b1, (cnt == 64), font(code, k)});
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic do_clr, input logic do_ref);
    @(posedge clk); #1;
    clear   = do_clr;
    refresh = do_ref;
    @(posedge clk); #1;
    clear   = 1'b0;
    refresh = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < LIMIT && !done; i++) begin
      @(negedge clk); #1;
      if (!busy) done = 1'b1;
    end
    chk({nm, "_done"}, done, 1'b1);
    if (done) chk({nm, "_busy_fall"}, cyc - last_acc, 1);
  endtask

  task automatic compare_stream(input string nm);
    int idx;
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    idx = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (idx < 0 && got_q[i] !== exp_q[i]) idx = i;
    end
    n_checks++;
    if (idx >= 0) begin
      n_fail++;
      $display("FAIL %s_bytes at %0d actual=%0h required=%0h", nm, idx, got_q[idx], exp_q[idx]);
    end
  endtask

  task automatic start_frame(input logic do_clr, input logic do_ref, input string nm);
    got_q.delete();
    pulse(do_clr, do_ref);
    chk({nm, "_busy_rise"}, busy, 1'b1);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    string        name;
    logic [3:0]   tile0;
    logic [127:0] exp16;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic [127:0] act16;
    logic [TW-1:0] ta, tb_;
    int lasts, low_cnt;
    bit reached;

    vecs[0] = '{"t2048",  4'd11, 128'h74545C00_7C447C00_1C107C00_7C547C00};
    vecs[1] = '{"t2",     4'd1,  128'h00000000_00000000_00000000_74545C00};
    vecs[2] = '{"t32768", 4'd15, 128'h10101000_10101000_10101000_10101000};
    vecs[3] = '{"t_empty",4'd0,  128'h0};
    vecs[4] = '{"t128",   4'd7,  128'h00000000_00007C00_74545C00_7C547C00};
    vecs[5] = '{"t8192",  4'd13, 128'h7C547C00_00007C00_5C547C00_74545C00};

    // ---- reset ----
    rst = 1'b1; tiles = '0; refresh = 1'b0; clear = 1'b0; bus.CMD_READY = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.CMD_VALID, bus.CMD_LAST, busy, bus.CMD_DATA, bus.CMD_IS_DATA}, '0);
    @(posedge clk); #2;
    rst = 1'b0;

    // ---- full clear at READY=1 ----
    ready_pct = 100;
    exp_q.delete(); model_clear();
    start_frame(1'b1, 1'b0, "clear");
    wait_done("clear");
    compare_stream("clear");
    lasts = 0;
    foreach (got_q[i]) if (got_q[i][8]) lasts++;
    chk("clear_last_count", lasts, 16);

    // ---- single-tile table ----
    for (int v = 0; v < 6; v++) begin
      tiles = '0;
      tiles[63:60] = vecs[v].tile0;
      exp_q.delete(); model_refresh(tiles);
      start_frame(1'b0, 1'b1, vecs[v].name);
      wait_done(vecs[v].name);
      compare_stream(vecs[v].name);
      act16 = '0;
      if (got_q.size() >= 19) for (int i = 0; i < 16; i++) act16 = {act16[119:0], got_q[3+i][7:0]};
      chk({vecs[v].name, "_row0_data16"}, act16, vecs[v].exp16);
    end
    chk("row1_page_cmd", (got_q.size() > ROW_LEN) ? got_q[ROW_LEN] : '0, {2'b00, 8'hB2});

    // ---- random tiles, same tiles with and without backpressure ----
    for (int n = 0; n < 3; n++) begin
      ta = {$urandom, $urandom};
      tiles = ta;
      exp_q.delete(); model_refresh(ta);
      ready_pct = 100;
      start_frame(1'b0, 1'b1, "rand_full");
      wait_done("rand_full");
      compare_stream("rand_full");
      ready_pct = 30;
      start_frame(1'b0, 1'b1, "rand_bp");
      tiles = ~ta;
      wait_done("rand_bp");
      compare_stream("rand_bp");
    end

    // ---- CLEAR and REFRESH together: clear first, then queued refresh ----
    ready_pct = 70;
    ta = {$urandom, $urandom};
    tiles = ta;
    exp_q.delete(); model_clear(); model_refresh(ta);
    start_frame(1'b1, 1'b1, "clr_ref");
    wait_done("clr_ref");
    compare_stream("clr_ref");

    // ---- queued refresh with new tiles, extra requests merge ----
    ready_pct = 60;
    ta = {$urandom, $urandom};
    tb_ = ~ta;
    tiles = ta;
    exp_q.delete(); model_refresh(ta); model_refresh(tb_);
    start_frame(1'b0, 1'b1, "queued");
    repeat (30) @(posedge clk);
    #1 tiles = tb_;
    pulse(1'b0, 1'b1);
    repeat (10) @(posedge clk);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    low_cnt = 0;
    for (int i = 0; i < LIMIT && got_q.size() < exp_q.size(); i++) begin
      @(negedge clk); #1;
      if (!busy && got_q.size() < exp_q.size()) low_cnt++;
    end
    chk("queued_busy_gap", low_cnt, 0);
    wait_done("queued");
    compare_stream("queued");

    // ---- asynchronous reset mid ROW_DATA ----
    ready_pct = 100;
    tiles = {4'd11, 60'h0};
    start_frame(1'b0, 1'b1, "rst_mid");
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk); #1;
      if (got_q.size() >= 10) reached = 1'b1;
    end
    chk("rst_mid_reached", reached, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {bus.CMD_VALID, bus.CMD_LAST, busy, bus.CMD_DATA, bus.CMD_IS_DATA}, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    got_q.delete();
    repeat (20) @(negedge clk);
    #1;
    chk("rst_quiet_bytes", got_q.size(), 0);
    chk("rst_quiet_busy", busy, 1'b0);

    // ---- recovery frame after reset ----
    exp_q.delete(); model_refresh(tiles);
    start_frame(1'b0, 1'b1, "post_rst");
    wait_done("post_rst");
    compare_stream("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_grid_renderer.md
Name: tile_grid_renderer

Overview:
- Parametrised successor to the fixed 4x4 2048 display path.
- Converts a packed grid of tile exponents into page/column command bytes and font-column data bytes for the SSD13xx-style serial controller.
- Handshake is valid/ready. Grid size, digit count, glyph width and panel geometry are configurable. Adds full-screen clear, right-justified decimal with blanking, an overflow glyph, and a queued refresh request.
- Sits between the game core (tile exponents) and the serial OLED controller.

Parameters:
- GRID_N, 4, tiles per side; grid row r maps to page r*(PAGES/GRID_N).
- EXP_W, 4, bits per tile exponent.
- DIGITS, 4, decimal digit positions per tile.
- GLYPH_W, 4, columns per digit: 3 font columns, then GLYPH_W-3 blank columns; must be >= 4.
- PAGES, 8, panel pages (8-pixel rows).
- COLS, 128, panel columns. Elaboration error unless GRID_N*DIGITS*GLYPH_W <= COLS and GRID_N <= PAGES.

Ports:
- CLK  in  1  system clock.
- ASYNC_RST  in  1  asynchronous reset, active-high.
- TILES  in  GRID_N*GRID_N*EXP_W  tile exponents, tile 0 (row 0, col 0) in the MSBs, row-major.
- REFRESH  in  1  one-cycle request to redraw the grid.
- CLEAR  in  1  one-cycle request to zero the whole panel.
- BUSY  out  1  high from request acceptance until the last byte is accepted.
- CMD_DATA  out  8  byte to the controller.
- CMD_IS_DATA  out  1  0 = command byte, 1 = GDDRAM data byte.
- CMD_LAST  out  1  marks the last byte of a transaction; the controller issues STOP after it.
- CMD_VALID  out  1  byte valid.
- CMD_READY  in  1  controller accepts the byte on the CLK edge where VALID&&READY.

Behaviour:
- Reset: CMD_VALID=0, CMD_DATA=0, CMD_IS_DATA=0, CMD_LAST=0, BUSY=0, FSM=IDLE, pending flag cleared. Applies immediately, including mid-frame.
- Handshake rules:
  - CMD_DATA, CMD_IS_DATA and CMD_LAST are registered and held stable while VALID && !READY.
  - VALID never drops without a transfer, except on reset.
  - No combinational path from READY to any output.
  - Next byte is presented the cycle after acceptance, so there are no bubbles when READY is held high.
- FSM states: IDLE, CLR_CMD, CLR_DATA, ROW_CMD, ROW_DATA.
- IDLE:
  - CLEAR wins over REFRESH: go to CLR_CMD with page=0. A simultaneous REFRESH sets pending.
  - REFRESH alone: latch TILES into an internal snapshot, go to ROW_CMD with row=0.
  - BUSY rises the cycle after the request.
- CLR_CMD: emits three command bytes 0xB0|page, 0x00, 0x10; CMD_LAST on the third; then CLR_DATA.
- CLR_DATA:
  - Emits COLS bytes of 0x00 with IS_DATA=1; LAST on the final byte.
  - Then page+1 -> CLR_CMD, or after page PAGES-1 -> IDLE.
- ROW_CMD: same three command bytes with page = row*(PAGES/GRID_N), start column 0; then ROW_DATA.
- ROW_DATA:
  - For tile c = 0..GRID_N-1, digit d = 0..DIGITS-1 (most significant first), column k = 0..GLYPH_W-1: emit glyph column k of the digit code.
  - Byte count is GRID_N*DIGITS*GLYPH_W (64 at defaults). LAST on the final byte.
  - Then row+1 -> ROW_CMD, or after row GRID_N-1 -> IDLE.
- Digit codes:
  - Exponent 0: empty tile, all digits BLANK.
  - Exponent e >= 1: decimal of 2^e, right-justified, leading positions BLANK.
  - If 2^e needs more than DIGITS digits: all positions OVF.
- Font columns, digits 0-9:
  - Col 0: 7C 00 74 54 1C 5C 7C 04 7C 5C
  - Col 1: 44 00 54 54 10 54 54 04 54 54
  - Col 2: 7C 7C 5C 7C 7C 74 74 7C 7C 7C
  - BLANK = 00 00 00. OVF = 10 10 10.
- Tile values come only from the snapshot; TILES changes during a frame have no effect.
- REFRESH while BUSY sets pending (one deep, extra requests merge). CLEAR while BUSY is ignored.
- Returning to IDLE with pending: clear pending, re-latch TILES, start ROW_CMD next cycle. BUSY stays high with no low gap.
- Counter widths: page/row counters use $clog2 of their range (min 1 bit); column counter $clog2(COLS+1). No wrap beyond the terminal counts above.

Decomposition:
- Package tile_grid_pkg holds:
  - digit-code type (4 bits, 0-9, BLANK=10, OVF=11);
  - font ROM constant (3 columns x 12 codes);
  - POW2_BCD constant table (2^e packed BCD for e up to 2^EXP_W-1);
  - command opcode constants 0xB0, 0x00, 0x10.
- Sub-module tile_digit_fmt: registered, one-cycle latency. Exponent in -> DIGITS digit codes out, with blanking and overflow. The FSM pre-fetches the next tile's digits one cycle before use.

Test Plan:
- Reset values: assert ASYNC_RST mid-ROW_DATA -> VALID/LAST/BUSY/DATA/IS_DATA all 0 in the same cycle. After release with READY=1, no bytes until a new request.
- CLEAR, defaults, READY=1 -> 1048 bytes total: 8 x (B0+p, 00, 10, then 128 x 00). 16 LAST pulses. BUSY low 1 cycle after the final byte.
- REFRESH with tile0=11 and all other tiles 0 -> row 0 byte stream is B0,00,10, then data 74 54 5C 00 7C 44 7C 00 1C 10 7C 00 7C 54 7C 00 followed by 48 x 00. Rows 1-3 use pages 2, 4, 6.
- Tile0=1 -> first 16 data bytes are 12 x 00 then 74 54 5C 00. Tile0=15 (32768, 5 digits) -> 4 x (10 10 10 00).
- Backpressure: READY randomly 30% high -> byte sequence identical to the READY=1 run, and DATA stable on every stalled cycle.
- Queued requests: REFRESH, then REFRESH again mid-frame with changed TILES -> two complete frames back to back. The second frame uses the new TILES. BUSY continuous. A third REFRESH in the same frame adds nothing.
